// File: rtl/octave_pkg.sv
// Shared types for the octave sequencing controller.
package octave_pkg;

  typedef enum logic [1:0] {
    K_IDLE,
    K_HOLD,
    K_REPEAT
  } key_state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/octave_ctrl_if.sv
// Board-side key/sweep inputs and step-command outputs of the octave controller.
interface octave_ctrl_if #(
  parameter int unsigned LEVELS = 10
) ();
  localparam int unsigned LW = $clog2(LEVELS);

  logic          key_up;
  logic          key_down;
  logic          sweep_en;
  logic          increase;
  logic          decrease;
  logic [LW-1:0] level;
  logic          at_max;
  logic          at_min;

  modport master (
    output key_up, key_down, sweep_en,
    input  increase, decrease, level, at_max, at_min
  );

  modport slave (
    input  key_up, key_down, sweep_en,
    output increase, decrease, level, at_max, at_min
  );
endinterface

// File: rtl/key_repeat.sv
// One push-button: synchroniser, arming, press/hold/auto-repeat FSM.
// req is combinational so the top registers it as the third edge of latency.
module key_repeat
  import octave_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic block,
  output logic pressed,
  output logic req,
  output logic idle
);
  localparam int unsigned MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LOAD  = CW'(REPEAT_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign pressed = armed_q & ~sync2_q;
  assign idle    = (state_q == K_IDLE);

  // Sync chain and arming. The synchroniser resets to "released", so fill_q
  // marks when sync2 carries a real sample; only then may it arm the key.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & sync2_q);
  end

  // Press / hold / repeat sequencing with request generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    if (block || !pressed) begin
      state_d = K_IDLE;
    end else begin
      case (state_q)
        K_IDLE: begin
          req     = 1'b1;
          state_d = K_HOLD;
          cnt_d   = HOLD_LOAD;
        end
        K_HOLD: begin
          if (cnt_q == '0) begin
            req     = 1'b1;
            state_d = K_REPEAT;
            cnt_d   = REP_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        K_REPEAT: begin
          if (cnt_q == '0) begin
            req   = 1'b1;
            cnt_d = REP_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = K_IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= '0;
      armed_q <= 1'b0;
      state_q <= K_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/octave_ctrl.sv
// Octave sequencing controller: two auto-repeat keys, ping-pong sweep,
// manual-priority arbitration, range clamp and octave level tracking.
module octave_ctrl
  import octave_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned SWEEP_CYCLES  = 50_000_000,
  parameter int unsigned LEVELS        = 10,
  parameter int unsigned RESET_LEVEL   = 5
) (
  input  logic         clk,
  input  logic         reset,
  octave_ctrl_if.slave bus
);
  localparam int unsigned LW = $clog2(LEVELS);
  localparam int unsigned SW = $clog2(SWEEP_CYCLES + 1);
  localparam logic [LW-1:0] MAX_LEVEL  = LW'(LEVELS - 1);
  localparam logic [LW-1:0] RST_LEVEL  = LW'(RESET_LEVEL);
  localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEP_CYCLES - 1);

  logic          up_pressed, up_req, up_idle;
  logic          dn_pressed, dn_req, dn_idle;
  logic          both, block, man_req, holdoff, at_max, at_min;
  logic          lock_q, lock_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  dir_t          dir_q, dir_d;
  logic [SW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [LW-1:0] level_q, level_d;

  key_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_key_up (
    .clk(clk), .reset(reset), .key_n(bus.key_up), .block(block),
    .pressed(up_pressed), .req(up_req), .idle(up_idle)
  );

  key_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_key_down (
    .clk(clk), .reset(reset), .key_n(bus.key_down), .block(block),
    .pressed(dn_pressed), .req(dn_req), .idle(dn_idle)
  );

  assign at_max  = (level_q == MAX_LEVEL);
  assign at_min  = (level_q == '0);
  assign both    = up_pressed & dn_pressed;
  assign block   = both | lock_q;
  assign man_req = up_req | dn_req;
  assign holdoff = inc_q | dec_q;

  assign bus.increase = inc_q;
  assign bus.decrease = dec_q;
  assign bus.level    = level_q;
  assign bus.at_max   = at_max;
  assign bus.at_min   = at_min;

  // Arbitration, sweep timer/direction, clamp and level update.
  // A sweep due during the post-pulse holdoff stays at its terminal count and
  // retries next cycle; a manual request in that cycle is dropped.
  always_comb begin
    lock_d      = both | (lock_q & (up_pressed | dn_pressed));
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    dir_d       = dir_q;
    sweep_cnt_d = sweep_cnt_q;
    level_d     = level_q;
    if (inc_q && !at_max) begin
      level_d = level_q + 1'b1;
    end else if (dec_q && !at_min) begin
      level_d = level_q - 1'b1;
    end
    if (man_req || !up_idle || !dn_idle) begin
      sweep_cnt_d = '0;
      if (!holdoff) begin
        if (up_req && !at_max) begin
          inc_d = 1'b1;
        end else if (dn_req && !at_min) begin
          dec_d = 1'b1;
        end
      end
    end else if (!bus.sweep_en) begin
      sweep_cnt_d = '0;
    end else if (sweep_cnt_q == SWEEP_LAST) begin
      if (!holdoff) begin
        sweep_cnt_d = '0;
        if (dir_q == DIR_UP) begin
          if (at_max) begin
            dir_d = DIR_DOWN;
            dec_d = 1'b1;
          end else begin
            inc_d = 1'b1;
          end
        end else begin
          if (at_min) begin
            dir_d = DIR_UP;
            inc_d = 1'b1;
          end else begin
            dec_d = 1'b1;
          end
        end
      end
    end else begin
      sweep_cnt_d = sweep_cnt_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q      <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      dir_q       <= DIR_UP;
      sweep_cnt_q <= '0;
      level_q     <= RST_LEVEL;
    end else begin
      lock_q      <= lock_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      dir_q       <= dir_d;
      sweep_cnt_q <= sweep_cnt_d;
      level_q     <= level_d;
    end
  end
endmodule
